// File: rtl/icap_frame_writer.sv
// Streams a full partial-reconfiguration write packet (header, FDRI burst from BRAM, pad frame,
// DESYNC tail) into the ICAP. Define ICAP_BITSWAP_EN to bit-reverse every byte on icap_i.
module icap_frame_writer #(
    parameter int unsigned FRAME_WORDS = 101,
    parameter logic [31:0] IDCODE      = 32'h23727093,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BASE_ADDR   = 104,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_frames,
    input  logic [31:0]       frame_address,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [31:0]       icap_i,
    output logic              icap_csib,
    output logic              icap_rdwrb,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned WW = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [WW-1:0] WLAST = WW'(FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        StIdle, StSetup, StHeader, StData, StPad, StTail, StClose
    } state_e;

    state_e             state_q;
    logic [31:0]        icap_q;
    logic               data_sel_q;
    logic [CNT_W-1:0]   nf_q;
    logic [31:0]        far_q;
    logic [4:0]         idx_q;
    logic [WW-1:0]      wcnt_q;
    logic [CNT_W-1:0]   fcnt_q;
    logic               aborted_q;
    logic [26:0]        wc;
    logic [31:0]        word;

    // FDRI length covers the data frames plus the trailing pad frame.
    assign wc = 27'((32'(nf_q) + 32'd1) * FRAME_WORDS);

    function automatic logic [31:0] hdr_word(input logic [4:0] i, input logic [31:0] far,
                                             input logic [26:0] cnt);
        case (i)
            5'd0:    return 32'hFFFFFFFF;
            5'd1:    return 32'h000000BB;
            5'd2:    return 32'h11220044;
            5'd3:    return 32'hFFFFFFFF;
            5'd4:    return 32'hAA995566;
            5'd5:    return 32'h20000000;
            5'd6:    return 32'h30008001;
            5'd7:    return 32'h00000007;
            5'd8:    return 32'h20000000;
            5'd9:    return 32'h20000000;
            5'd10:   return 32'h30018001;
            5'd11:   return IDCODE;
            5'd12:   return 32'h30002001;
            5'd13:   return far;
            5'd14:   return 32'h20000000;
            5'd15:   return 32'h30008001;
            5'd16:   return 32'h00000001;
            5'd17:   return 32'h20000000;
            5'd18:   return 32'h30004000;
            5'd19:   return {5'b01010, cnt};
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic logic [31:0] tail_word(input logic [2:0] i);
        case (i)
            3'd0, 3'd4: return 32'h30008001;
            3'd1:       return 32'h00000007;
            3'd5:       return 32'h0000000D;
            default:    return 32'h20000000;
        endcase
    endfunction

`ifdef ICAP_BITSWAP_EN
    function automatic logic [31:0] byte_swap_bits(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*i+j] = w[8*i+7-j];
            end
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            icap_q     <= '0;
            data_sel_q <= 1'b0;
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rd_addr    <= BASE;
            nf_q       <= '0;
            far_q      <= '0;
            idx_q      <= '0;
            wcnt_q     <= '0;
            fcnt_q     <= '0;
            aborted_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (num_frames == '0) begin
                            err <= 1'b1;
                        end else begin
                            nf_q       <= num_frames;
                            far_q      <= frame_address;
                            state_q    <= StSetup;
                            icap_rdwrb <= 1'b0;
                            busy       <= 1'b1;
                            rd_addr    <= BASE;
                            aborted_q  <= 1'b0;
                        end
                    end
                end
                StSetup: begin
                    state_q   <= StHeader;
                    icap_csib <= 1'b0;
                    icap_q    <= hdr_word(5'd0, far_q, wc);
                    idx_q     <= 5'd1;
                end
                StHeader: begin
                    if (idx_q == 5'd20) begin
                        // rd_addr held at BASE through the header, so rd_data already
                        // carries word 0 when DATA begins.
                        state_q    <= StData;
                        data_sel_q <= 1'b1;
                        rd_addr    <= rd_addr + ADDR_W'(1);
                        wcnt_q     <= '0;
                        fcnt_q     <= nf_q;
                    end else begin
                        icap_q <= hdr_word(idx_q, far_q, wc);
                        idx_q  <= idx_q + 5'd1;
                    end
                end
                StData: begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    if (abort) begin
                        state_q    <= StTail;
                        data_sel_q <= 1'b0;
                        icap_q     <= tail_word(3'd0);
                        idx_q      <= 5'd1;
                        aborted_q  <= 1'b1;
                    end else if (wcnt_q == WLAST) begin
                        wcnt_q <= '0;
                        fcnt_q <= fcnt_q - CNT_W'(1);
                        if (fcnt_q == CNT_W'(1)) begin
                            state_q    <= StPad;
                            data_sel_q <= 1'b0;
                            icap_q     <= '0;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + WW'(1);
                    end
                end
                StPad: begin
                    if (abort || wcnt_q == WLAST) begin
                        state_q   <= StTail;
                        icap_q    <= tail_word(3'd0);
                        idx_q     <= 5'd1;
                        aborted_q <= aborted_q | abort;
                    end else begin
                        wcnt_q <= wcnt_q + WW'(1);
                    end
                end
                StTail: begin
                    if (idx_q == 5'd8) begin
                        state_q   <= StClose;
                        icap_csib <= 1'b1;
                        icap_q    <= '0;
                    end else begin
                        icap_q <= tail_word(idx_q[2:0]);
                        idx_q  <= idx_q + 5'd1;
                    end
                end
                StClose: begin
                    state_q    <= StIdle;
                    icap_rdwrb <= 1'b1;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    err        <= aborted_q;
                    rd_addr    <= BASE;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // BRAM output register feeds icap_i directly during DATA to keep one word per cycle.
    always_comb begin
        word = data_sel_q ? rd_data : icap_q;
`ifdef ICAP_BITSWAP_EN
        icap_i = byte_swap_bits(word);
`else
        icap_i = word;
`endif
    end

endmodule

// File: tb/tb_icap_frame_writer.sv
// Scoreboard bench for icap_frame_writer: a packet model fills expected-word and pulse queues,
// a negedge monitor pops and compares whatever the DUT drives.
module tb_icap_frame_writer;

    localparam int FW   = 101;
    localparam int AW   = 10;
    localparam int BASE = 104;
    localparam int CW   = 16;
    localparam logic [31:0] IDC = 32'h23727093;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] num_frames;
    logic [31:0]   frame_address;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic [31:0]   icap_i;
    logic          icap_csib;
    logic          icap_rdwrb;
    logic          busy;
    logic          done;
    logic          err;

    icap_frame_writer #(
        .FRAME_WORDS(FW),
        .IDCODE     (IDC),
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .num_frames   (num_frames),
        .frame_address(frame_address),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .icap_i       (icap_i),
        .icap_csib    (icap_csib),
        .icap_rdwrb   (icap_rdwrb),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_w[$];
    logic [1:0]  exp_ev[$];
    int cyc = 0;
    int last_low = 0;
    bit prev_low = 0;

    function automatic logic [31:0] sw(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef ICAP_BITSWAP_EN
        for (int b = 0; b < 32; b++) r[b] = w[(b / 8) * 8 + 7 - (b % 8)];
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Expected packet: header, then 'post' words of data-then-pad (cut short by abort), tail.
    task automatic push_run(input int nf, input logic [31:0] far, input int abort_pos,
                            output int n_low);
        logic [31:0] h [20];
        int nd;
        int post;
        int unsigned wc;
        nd = nf * FW;
        wc = ((nf + 1) * FW) & 32'h07FF_FFFF;
        h = '{32'hFFFFFFFF, 32'h000000BB, 32'h11220044, 32'hFFFFFFFF, 32'hAA995566,
              32'h20000000, 32'h30008001, 32'h00000007, 32'h20000000, 32'h20000000,
              32'h30018001, IDC, 32'h30002001, far, 32'h20000000, 32'h30008001,
              32'h00000001, 32'h20000000, 32'h30004000, 32'h50000000 | wc};
        for (int i = 0; i < 20; i++) exp_w.push_back(sw(h[i]));
        post = (abort_pos > 0) ? abort_pos : nd + FW;
        for (int k = 0; k < post; k++)
            exp_w.push_back(k < nd ? sw(mem[(BASE + k) % 1024]) : 32'h0);
        exp_w.push_back(sw(32'h30008001)); exp_w.push_back(sw(32'h00000007));
        exp_w.push_back(sw(32'h20000000)); exp_w.push_back(sw(32'h20000000));
        exp_w.push_back(sw(32'h30008001)); exp_w.push_back(sw(32'h0000000D));
        exp_w.push_back(sw(32'h20000000)); exp_w.push_back(sw(32'h20000000));
        exp_ev.push_back({1'b1, abort_pos > 0});
        n_low = 28 + post;
    endtask

    task automatic run(input int nf, input logic [31:0] far, input int abort_pos,
                       input bit mid, input bit hdr_abort, input bit tail_abort);
        int exp_n;
        int n;
        bit got;
        push_run(nf, far, abort_pos, exp_n);
        @(negedge clk);
        num_frames = CW'(nf);
        frame_address = far;
        start = 1'b1;
        n = 0;
        got = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (!icap_csib) n++;
            if (done || err) got = 1;
            if (!icap_csib && abort_pos > 0 && n == 20 + abort_pos) abort = 1'b1;
            if (!icap_csib && hdr_abort && n == 4) abort = 1'b1;
            if (!icap_csib && tail_abort && n == exp_n - 3) abort = 1'b1;
            if (!icap_csib && mid && n == 40) begin
                start = 1'b1;
                frame_address = ~far;
                num_frames = CW'(nf + 5);
            end
        end
        abort = 1'b0;
        start = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        chk("csib_low_count", 64'(n), 64'(exp_n));
        @(negedge clk);
        chk("queues_drained", {32'(exp_w.size()), 32'(exp_ev.size())}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            logic [31:0] e;
            logic [1:0]  ev;
            cyc++;
            if (prev_low && icap_csib)
                chk("close_cycle", {62'd0, busy, icap_rdwrb}, 64'b10);
            prev_low = !icap_csib;
            if (!icap_csib) begin
                if (exp_w.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL icap_word_extra: got %h expected none", icap_i);
                end else begin
                    e = exp_w.pop_front();
                    chk("icap_word", {31'd0, icap_rdwrb, icap_i}, {32'd0, e});
                end
                last_low = cyc;
            end
            if (done || err) begin
                if (exp_ev.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pulse_extra: got done=%b err=%b expected none", done, err);
                end else begin
                    ev = exp_ev.pop_front();
                    chk("done_err", {62'd0, done, err}, {62'd0, ev});
                    if (done)
                        chk("done_timing",
                            64'({32'(cyc - last_low), busy, icap_csib, icap_rdwrb, rd_addr}),
                            64'({32'd2, 1'b0, 1'b1, 1'b1, AW'(BASE)}));
                end
            end
        end else begin
            prev_low = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nf;
        int ap;
        int dummy;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        num_frames = '0;
        frame_address = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        #3;
        chk("reset_state", 64'({icap_i, icap_csib, icap_rdwrb, busy, done, err, rd_addr}),
            64'({32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AW'(BASE)}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run(1, 32'h00428004, 0, 0, 0, 0);

        // Zero count: err pulse only, no ICAP activity.
        exp_ev.push_back(2'b01);
        @(negedge clk);
        num_frames = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("zero_count_idle", {61'd0, busy, icap_csib, icap_rdwrb}, 64'b011);
            @(negedge clk);
        end
        chk("zero_count_err_seen", 64'(exp_ev.size()), 64'd0);

        run(3, $urandom, 50, 0, 0, 0);
        run(2, $urandom, 0, 1, 1, 1);

        // Reset during header word 5, then a clean full run.
        push_run(2, 32'h12345678, 0, dummy);
        @(negedge clk);
        num_frames = CW'(2);
        frame_address = 32'h12345678;
        start = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (!icap_csib) n++;
        end
        chk("reached_header_word5", 64'(n), 64'd6);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", 64'({icap_i, icap_csib, icap_rdwrb, busy, done, err, rd_addr}),
            64'({32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AW'(BASE)}));
        exp_w.delete();
        exp_ev.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(1, $urandom, 0, 0, 0, 0);

        for (int r = 0; r < 4; r++) begin
            nf = $urandom_range(1, 3);
            ap = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (nf + 1) * FW) : 0;
            run(nf, $urandom, ap, (ap == 0 || ap > 25), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1);
        end

        run(10, $urandom, 0, 0, 0, 0);       // BRAM address wraps past 1023
        run(1, $urandom, 2 * FW, 0, 0, 0);   // abort on the final pad word
        run(2, $urandom, FW * 2 + 1, 0, 0, 0); // abort on the first pad word

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
